riio_gpi_rx_conditioner: RTL and testbench

//  Core-side receive conditioner for a general-purpose input pad; the input-direction counterpart of the GPO pad driver.

---
 rtl/riio_gpi_rx_conditioner.sv | 178 +++++++++++++++++
 tb/tb_riio_gpi_rx_conditioner.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/riio_gpi_rx_conditioner.sv
// Receive conditioner for a general-purpose input pad: pad enable/pull control, synchroniser, debouncer.
// Optional sticky edge interrupt latch is built when the macro GPI_IRQ_EN is defined.
module riio_gpi_rx_conditioner #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             CLK_I,
    input  logic             RST_I,
    input  logic             EN_I,
    input  logic [1:0]       PULL_I,
    input  logic [CNT_W-1:0] DEB_CYCLES_I,
    input  logic             DI_I,
    output logic             IE_O,
    output logic             PE_O,
    output logic             PS_O,
    output logic             DATA_O,
    output logic             RISE_O,
    output logic             FALL_O,
    output logic             GLITCH_O
`ifdef GPI_IRQ_EN
    ,
    input  logic [1:0]       IRQ_MODE_I,
    input  logic             IRQ_CLR_I,
    output logic             IRQ_O
`endif
);

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        ARM    = 2'd1,
        STABLE = 2'd2,
        QUAL   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    // Last blanking count: covers the pad enable delay plus a full sync-chain flush.
    localparam logic [CNT_W-1:0] ARM_LAST = CNT_W'(SYNC_STAGES + 1);

    state_t                 state_r;
    state_t                 state_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       cnt_s;
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_s;
    logic                   data_s;
    logic                   rise_s;
    logic                   fall_s;
    logic                   glitch_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + CNT_ONE;
        end
    endfunction

    assign sync_s = sync_r[SYNC_STAGES-1];

    // Synchroniser chain on the asynchronous pad input; shifts every cycle regardless of state.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], DI_I};
        end
    end

    // Registered pad controls.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            IE_O <= 1'b0;
            PE_O <= 1'b0;
            PS_O <= 1'b0;
        end else begin
            IE_O <= EN_I;
            PE_O <= (PULL_I == 2'b01) || (PULL_I == 2'b10);
            PS_O <= (PULL_I == 2'b10);
        end
    end

    // Debounce FSM next-state, counter and output-update logic.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        data_s   = DATA_O;
        rise_s   = 1'b0;
        fall_s   = 1'b0;
        glitch_s = 1'b0;
        if (!EN_I) begin
            state_s = OFF;
            cnt_s   = CNT_ZERO;
        end else begin
            case (state_r)
                OFF: begin
                    state_s = ARM;
                    cnt_s   = CNT_ZERO;
                end
                ARM: begin
                    if (cnt_r == ARM_LAST) begin
                        data_s  = sync_s;
                        cnt_s   = CNT_ZERO;
                        state_s = STABLE;
                    end else begin
                        cnt_s = sat_inc(cnt_r);
                    end
                end
                STABLE: begin
                    if (sync_s != DATA_O) begin
                        if (DEB_CYCLES_I == CNT_ZERO) begin
                            data_s = sync_s;
                            rise_s = sync_s;
                            fall_s = ~sync_s;
                        end else begin
                            state_s = QUAL;
                            cnt_s   = CNT_ONE;
                        end
                    end else begin
                        state_s = STABLE;
                    end
                end
                QUAL: begin
                    if (sync_s == DATA_O) begin
                        state_s  = STABLE;
                        cnt_s    = CNT_ZERO;
                        glitch_s = 1'b1;
                    end else if (cnt_r >= DEB_CYCLES_I) begin
                        // >= so that lowering the debounce length mid-run commits at once.
                        data_s  = sync_s;
                        rise_s  = sync_s;
                        fall_s  = ~sync_s;
                        cnt_s   = CNT_ZERO;
                        state_s = STABLE;
                    end else begin
                        cnt_s = sat_inc(cnt_r);
                    end
                end
                default: begin
                    state_s = OFF;
                    cnt_s   = CNT_ZERO;
                end
            endcase
        end
    end

    // FSM state, counter and registered level/strobe outputs.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_r  <= OFF;
            cnt_r    <= CNT_ZERO;
            DATA_O   <= 1'b0;
            RISE_O   <= 1'b0;
            FALL_O   <= 1'b0;
            GLITCH_O <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            DATA_O   <= data_s;
            RISE_O   <= rise_s;
            FALL_O   <= fall_s;
            GLITCH_O <= glitch_s;
        end
    end

`ifdef GPI_IRQ_EN
    // Sticky interrupt latch fed by the registered strobes; a set beats a clear in the same cycle.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            IRQ_O <= 1'b0;
        end else begin
            IRQ_O <= (RISE_O & IRQ_MODE_I[0]) | (FALL_O & IRQ_MODE_I[1]) | (IRQ_O & ~IRQ_CLR_I);
        end
    end
`endif

endmodule

// File: tb/tb_riio_gpi_rx_conditioner.sv
// Self-checking bench for riio_gpi_rx_conditioner: directed steps plus randomized pad activity
// compared every cycle against a run-length reference model.
module tb_riio_gpi_rx_conditioner;

    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [1:0]       pull;
    logic [CNT_W-1:0] deb;
    logic             di;
    logic             ie, pe, ps, data, rise, fall, glitch;
`ifdef GPI_IRQ_EN
    logic [1:0]       irq_mode;
    logic             irq_clr;
    logic             irq;
`endif

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic m_pipe[$];
    int   en_age;
    int   run;
    logic m_ie, m_pe, m_ps, m_data, m_rise, m_fall, m_glitch, m_irq;

    always #5 clk = ~clk;

    riio_gpi_rx_conditioner #(.SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W)) dut (
        .CLK_I(clk), .RST_I(rst), .EN_I(en), .PULL_I(pull), .DEB_CYCLES_I(deb), .DI_I(di),
        .IE_O(ie), .PE_O(pe), .PS_O(ps), .DATA_O(data), .RISE_O(rise), .FALL_O(fall),
        .GLITCH_O(glitch)
`ifdef GPI_IRQ_EN
        , .IRQ_MODE_I(irq_mode), .IRQ_CLR_I(irq_clr), .IRQ_O(irq)
`endif
    );

    task automatic check(input string tag, input logic got, input logic exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Model: s is the pad value SYNC_STAGES edges old; a level change is accepted after
    // DEB+1 consecutive differing samples, and an interrupted run is a glitch.
    task automatic model_edge();
        logic s_m;
`ifdef GPI_IRQ_EN
        m_irq = rst ? 1'b0 : ((m_rise & irq_mode[0]) | (m_fall & irq_mode[1]) | (m_irq & ~irq_clr));
`else
        m_irq = 1'b0;
`endif
        m_rise = 1'b0; m_fall = 1'b0; m_glitch = 1'b0;
        if (rst) begin
            m_pipe = {};
            repeat (SYNC_STAGES) m_pipe.push_back(1'b0);
            en_age = 0; run = 0;
            m_ie = 1'b0; m_pe = 1'b0; m_ps = 1'b0; m_data = 1'b0;
        end else begin
            m_ie = en;
            m_pe = (pull == 2'd1) || (pull == 2'd2);
            m_ps = (pull == 2'd2);
            s_m = m_pipe.pop_front();
            m_pipe.push_back(di);
            if (!en) begin
                en_age = 0; run = 0;
            end else begin
                if (en_age < 1000) en_age++;
                if (en_age == SYNC_STAGES + 3) begin
                    m_data = s_m; run = 0;
                end else if (en_age > SYNC_STAGES + 3) begin
                    if (s_m != m_data) begin
                        run++;
                        if (run >= int'(deb) + 1) begin
                            m_data = s_m; m_rise = s_m; m_fall = ~s_m; run = 0;
                        end
                    end else begin
                        if (run > 0) m_glitch = 1'b1;
                        run = 0;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("ie", ie, m_ie);
        check("pe", pe, m_pe);
        check("ps", ps, m_ps);
        check("data", data, m_data);
        check("rise", rise, m_rise);
        check("fall", fall, m_fall);
        check("glitch", glitch, m_glitch);
`ifdef GPI_IRQ_EN
        check("irq", irq, m_irq);
`endif
    endtask

    // Ticks until DATA_O equals lvl; returns the number of ticks (bounded by 20).
    task automatic wait_level(input logic lvl, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (data !== lvl && n < 20);
    endtask

    initial begin
        int n;
        int gl_cnt;
        int fl_cnt;
        int hold;
        rst = 1'b1; en = 1'b0; pull = 2'b00; deb = 8'd4; di = 1'b1;
`ifdef GPI_IRQ_EN
        irq_mode = 2'b00; irq_clr = 1'b0;
`endif
        m_rise = 1'b0; m_fall = 1'b0; m_irq = 1'b0;

        // Reset with the pad high
        repeat (3) tick();
        check("rst_data", data, 1'b0);
        check("rst_ie", ie, 1'b0);
        check("rst_rise", rise, 1'b0);

        // Enable with pull-up, DEB=4, pad high
        rst = 1'b0; en = 1'b1; pull = 2'b10;
        tick();
        check("en_ie", ie, 1'b1);
        check("en_ps", ps, 1'b1);
        repeat (3) tick();
        check("arm_data_low", data, 1'b0);
        tick();
        check("arm_preload", data, 1'b1);
        check("arm_no_rise", rise, 1'b0);
        repeat (4) tick();

        // Debounced fall: 7 cycles from the pad edge
        di = 1'b0;
        wait_level(1'b0, n);
        check_int("fall_latency", n, 7);
        check("fall_strobe", fall, 1'b1);
        tick();
        check("fall_one_cycle", fall, 1'b0);
        di = 1'b1;
        wait_level(1'b1, n);
        check_int("rise_latency", n, 7);
        check("rise_strobe", rise, 1'b1);
        repeat (3) tick();

        // Glitch: 3-cycle low pulse is rejected
        gl_cnt = 0; fl_cnt = 0;
        di = 1'b0;
        repeat (3) begin tick(); gl_cnt += int'(glitch); fl_cnt += int'(fall); end
        di = 1'b1;
        repeat (10) begin tick(); gl_cnt += int'(glitch); fl_cnt += int'(fall); end
        check_int("glitch_count", gl_cnt, 1);
        check_int("glitch_no_fall", fl_cnt, 0);
        check("glitch_data", data, 1'b1);

        // Bypass: DEB=0 follows the pad after 3 cycles
        deb = 8'd0; di = 1'b0;
        wait_level(1'b0, n);
        check_int("bypass_fall_latency", n, 3);
        di = 1'b1;
        wait_level(1'b1, n);
        check_int("bypass_rise_latency", n, 3);
        check("bypass_rise", rise, 1'b1);
        repeat (2) tick();

        // Disable during qualification: level held, no strobe
        deb = 8'd4; di = 1'b0;
        repeat (4) tick();
        en = 1'b0;
        tick();
        check("dis_data_held", data, 1'b1);
        check("dis_no_fall", fall, 1'b0);
        check("dis_ie", ie, 1'b0);
        repeat (8) tick();
        en = 1'b1;
        repeat (8) tick();
        check("reen_preload", data, 1'b0);

        // Reset during qualification aborts it
        di = 1'b1;
        repeat (4) tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (10) tick();
        check("post_rst_data", data, 1'b1);

        // Randomized pad activity, debounce lengths, enables and resets
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                di = 1'($urandom);
                hold = $urandom_range(1, 8);
            end
            hold--;
            if ($urandom_range(0, 39) == 0) deb = 8'($urandom_range(0, 6));
            en   = ($urandom_range(0, 199) != 0);
            rst  = ($urandom_range(0, 499) == 0);
            pull = 2'($urandom);
`ifdef GPI_IRQ_EN
            irq_mode = 2'($urandom);
            irq_clr  = ($urandom_range(0, 7) == 0);
`endif
            tick();
        end
        rst = 1'b0; en = 1'b1;

`ifdef GPI_IRQ_EN
        // IRQ: rise-mode set beats a coincident clear, clear alone drops it, wrong edges ignored
        deb = 8'd0; irq_mode = 2'b01; irq_clr = 1'b0; di = 1'b0;
        repeat (10) tick();
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        di = 1'b1;
        n = 0;
        do begin tick(); n++; end while (rise !== 1'b1 && n < 20);
        check("irq_rise_seen", rise, 1'b1);
        irq_clr = 1'b1;
        tick();
        check("irq_set_wins", irq, 1'b1);
        tick();
        check("irq_clear", irq, 1'b0);
        irq_clr = 1'b0;
        di = 1'b0;
        repeat (6) tick();
        check("irq_fall_ignored", irq, 1'b0);
        irq_mode = 2'b10; di = 1'b1;
        repeat (6) tick();
        check("irq_mode10_rise", irq, 1'b0);
        check("irq_level", data, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
